// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// resident program base-address table and watchdog limit.
package prog_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FLUSH,
      S_FIN
   } state_e;

   localparam int unsigned NUM_BASE = 3;
   localparam logic [31:0] PROG_BASE [NUM_BASE] = '{32'd0, 32'd256, 32'd512};

   localparam int unsigned WDOG_LIM = 1000;

   // Indices beyond the table fall back to address 0.
   function automatic logic [31:0] prog_base_addr(input int unsigned idx);
      logic [$clog2(NUM_BASE)-1:0] sel;
      sel = idx[$clog2(NUM_BASE)-1:0];
      if (idx >= NUM_BASE) return '0;
      return PROG_BASE[sel];
   endfunction

endpackage

// File: rtl/prog_cyc_ctr.sv
// Saturating cycle counter: clear has priority, then increment while enabled,
// otherwise hold.
module prog_cyc_ctr #(
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/prog_seq.sv
// Program sequencer: launches NPROG resident programs in turn, counts RUN cycles
// and drains the pipeline after Done. Define PROG_SEQ_WDOG_EN for the watchdog abort.
module prog_seq
   import prog_seq_pkg::*;
#(
   parameter int unsigned L     = 10,
   parameter int unsigned NPROG = 3,
   parameter int unsigned CW    = 16,
   parameter int unsigned DRAIN = 2
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic                     Done,
   output logic                     PcLoad,
   output logic [L-1:0]             PcLoadAddr,
   output logic                     Run,
   output logic                     Ack,
   output logic [$clog2(NPROG)-1:0] ProgIdx,
   output logic [CW-1:0]            CycCnt,
   output logic                     AllDone,
   output logic                     Fault
);

   localparam int unsigned IW = $clog2(NPROG);
   localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   state_e         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [L-1:0]   addr_q, addr_d;
   logic [DW-1:0]  drain_q, drain_d;
   logic           all_done_q, all_done_d;
   logic           pc_load_q, pc_load_d;
   logic           run_q, run_d;
   logic           ack_q, ack_d;
   logic           wdog_trip;
   logic           cnt_clr, cnt_en;
`ifdef PROG_SEQ_WDOG_EN
   logic           fault_q, fault_d;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      drain_d    = drain_q;
      all_done_d = all_done_q;
      wdog_trip  = 1'b0;
`ifdef PROG_SEQ_WDOG_EN
      fault_d    = fault_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (Start && !all_done_q) begin
               state_d = S_LOAD;
               addr_d  = L'(prog_base_addr(32'(idx_q)));
            end
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            drain_d = '0;
            if (Done) begin
               state_d = (DRAIN == 0) ? S_FIN : S_FLUSH;
            end
`ifdef PROG_SEQ_WDOG_EN
            else if (32'(CycCnt) >= WDOG_LIM) begin
               wdog_trip = 1'b1;
               state_d   = S_FIN;
               fault_d   = 1'b1;
            end
`endif
         end
         S_FLUSH: begin
            if (drain_q == DW'(DRAIN - 1)) begin
               state_d = S_FIN;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            if (idx_q == IW'(NPROG - 1)) begin
               all_done_d = 1'b1;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      pc_load_d = (state_d == S_LOAD);
      run_d     = (state_d == S_RUN) || (state_d == S_FLUSH);
      ack_d     = (state_d == S_FIN);
   end

   assign cnt_clr = (state_q == S_LOAD);
   assign cnt_en  = (state_q == S_RUN) && !wdog_trip;

   prog_cyc_ctr #(
      .CW(CW)
   ) u_cyc_ctr (
      .clk  (Clk),
      .rst_n(Reset),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (CycCnt)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         addr_q     <= '0;
         drain_q    <= '0;
         all_done_q <= 1'b0;
         pc_load_q  <= 1'b0;
         run_q      <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         drain_q    <= drain_d;
         all_done_q <= all_done_d;
         pc_load_q  <= pc_load_d;
         run_q      <= run_d;
         ack_q      <= ack_d;
      end
   end

`ifdef PROG_SEQ_WDOG_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign Fault = fault_q;
`else
   assign Fault = 1'b0;
`endif

   assign PcLoad     = pc_load_q;
   assign PcLoadAddr = addr_q;
   assign Run        = run_q;
   assign Ack        = ack_q;
   assign ProgIdx    = idx_q;
   assign AllDone    = all_done_q;

endmodule

// File: tb/tb_prog_seq.sv
// Randomized bench for prog_seq with a transaction-level expectation model;
// a second instance with a 3-bit counter exercises saturation.
module tb_prog_seq;

   localparam int unsigned NPROG   = 3;
   localparam int unsigned DRAIN   = 2;
   localparam int unsigned WDOG    = 1000;
   localparam int unsigned SAT_MAX = 7;

   logic        Clk   = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic        Done  = 1'b0;

   logic        PcLoad, Run, Ack, AllDone, Fault;
   logic [9:0]  PcLoadAddr;
   logic [1:0]  ProgIdx;
   logic [15:0] CycCnt;

   logic        PcLoadS, RunS, AckS, AllDoneS, FaultS;
   logic [9:0]  PcLoadAddrS;
   logic [1:0]  ProgIdxS;
   logic [2:0]  CycCntS;

   int unsigned base_tab [NPROG] = '{0, 256, 512};
   int unsigned exp_idx;
   bit          exp_all;
   bit          sat_ok;
   int unsigned n_chk;
   int unsigned n_bad;
   int unsigned wd_cnt;

   prog_seq #(.L(10), .NPROG(NPROG), .CW(16), .DRAIN(DRAIN)) u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done),
      .PcLoad(PcLoad), .PcLoadAddr(PcLoadAddr), .Run(Run), .Ack(Ack),
      .ProgIdx(ProgIdx), .CycCnt(CycCnt), .AllDone(AllDone), .Fault(Fault)
   );

   prog_seq #(.L(10), .NPROG(NPROG), .CW(3), .DRAIN(DRAIN)) u_sat (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done),
      .PcLoad(PcLoadS), .PcLoadAddr(PcLoadAddrS), .Run(RunS), .Ack(AckS),
      .ProgIdx(ProgIdxS), .CycCnt(CycCntS), .AllDone(AllDoneS), .Fault(FaultS)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned sat(input int unsigned n);
      return (n > SAT_MAX) ? SAT_MAX : n;
   endfunction

   task automatic check_cnt(input string tag, input int unsigned n);
      check(tag, 32'(CycCnt), n);
      if (sat_ok) check({tag, "_sat"}, 32'(CycCntS), sat(n));
   endtask

   function automatic logic coin();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One complete program: launch, n RUN cycles with Done on the last, drain, ack.
   task automatic run_prog(input int unsigned n, input bit noise);
      int unsigned lat;
      int unsigned idle_n;
      Start = 1'b1;
      Done  = noise ? coin() : 1'b0;
      tick();
      check("pcload", 32'(PcLoad), 1);
      check("pcaddr", 32'(PcLoadAddr), base_tab[exp_idx]);
      check("idx_load", 32'(ProgIdx), exp_idx);
      check("run_load", 32'(Run), 0);
      Start = noise ? coin() : 1'b0;
      Done  = noise ? coin() : 1'b0;
      tick();
      for (int unsigned k = 1; k <= n; k++) begin
         check("run", 32'(Run), 1);
         check("pcload_run", 32'(PcLoad), 0);
         check("ack_run", 32'(Ack), 0);
         check_cnt("cyc_run", k - 1);
         Start = noise ? coin() : 1'b0;
         Done  = (k == n);
         tick();
      end
      lat = 1;
      while (Ack !== 1'b1 && lat <= DRAIN + 4) begin
         check("run_flush", 32'(Run), 1);
         check_cnt("cyc_flush", n);
         Start = noise ? coin() : 1'b0;
         Done  = noise ? coin() : 1'b0;
         tick();
         lat++;
      end
      check("ack_lat", lat, DRAIN + 1);
      check("ack", 32'(Ack), 1);
      check("run_fin", 32'(Run), 0);
      check("fault_fin", 32'(Fault), 0);
      check_cnt("cyc_fin", n);
      if (exp_idx == NPROG - 1) exp_all = 1'b1;
      else exp_idx++;
      Start = 1'b0;
      Done  = noise ? coin() : 1'b0;
      tick();
      check("ack_clr", 32'(Ack), 0);
      check("idx_next", 32'(ProgIdx), exp_idx);
      check("alldone", 32'(AllDone), 32'(exp_all));
      check_cnt("cyc_idle", n);
      idle_n = $urandom_range(3, 0);
      repeat (idle_n) begin
         Done = noise ? coin() : 1'b0;
         tick();
         check("idle_run", 32'(Run), 0);
         check("idle_pcload", 32'(PcLoad), 0);
         check("idle_idx", 32'(ProgIdx), exp_idx);
         check_cnt("idle_cyc", n);
      end
      Done = 1'b0;
   endtask

   initial begin
      n_chk   = 0;
      n_bad   = 0;
      exp_idx = 0;
      exp_all = 1'b0;
      sat_ok  = 1'b1;
      wd_cnt  = 0;

      // Start held while in reset must not launch anything.
      Reset = 1'b0;
      Start = 1'b1;
      repeat (3) begin
         tick();
         check("rst_pcload", 32'(PcLoad), 0);
         check("rst_run", 32'(Run), 0);
         check("rst_idx", 32'(ProgIdx), 0);
         check("rst_addr", 32'(PcLoadAddr), 0);
         check("rst_fault", 32'(Fault), 0);
         check_cnt("rst_cyc", 0);
      end
      Start = 1'b0;
      Reset = 1'b1;
      tick();
      check("idle_first", 32'(PcLoad), 0);

      run_prog(5, 1'b0);

      // Reset dropped in FLUSH while program 1 is draining.
      Start = 1'b1;
      tick();
      check("rf_addr", 32'(PcLoadAddr), base_tab[1]);
      Start = 1'b0;
      tick();
      for (int unsigned k = 1; k <= 3; k++) begin
         Done = (k == 3);
         tick();
      end
      Done = 1'b0;
      check("rf_flush_run", 32'(Run), 1);
      #2 Reset = 1'b0;
      #1;
      check("rf_run", 32'(Run), 0);
      check("rf_ack", 32'(Ack), 0);
      check("rf_idx", 32'(ProgIdx), 0);
      check_cnt("rf_cyc", 0);
      @(negedge Clk);
      Reset = 1'b1;
      exp_idx = 0;
      exp_all = 1'b0;
      repeat (4) begin
         tick();
         check("rf_post_ack", 32'(Ack), 0);
         check("rf_post_run", 32'(Run), 0);
         check("rf_post_pcl", 32'(PcLoad), 0);
      end

      for (int p = 0; p < 3; p++) begin
         run_prog((p == 0) ? $urandom_range(12, 8) : $urandom_range(12, 1), 1'b1);
      end
      check("alldone_final", 32'(AllDone), 1);

      Start = 1'b1;
      repeat (3) begin
         tick();
         check("start_ignored", 32'(PcLoad), 0);
         check("alldone_run", 32'(Run), 0);
         check("alldone_idx", 32'(ProgIdx), NPROG - 1);
      end
      Start = 1'b0;

      // Long RUN without Done; the saturating twin diverges from here on.
      Reset = 1'b0;
      #3 Reset = 1'b1;
      sat_ok  = 1'b0;
      exp_idx = 0;
      exp_all = 1'b0;
      check("rst2_alldone", 32'(AllDone), 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("wd_pcload", 32'(PcLoad), 1);
      tick();
`ifdef PROG_SEQ_WDOG_EN
      while (Ack !== 1'b1 && wd_cnt < WDOG + 50) begin
         tick();
         wd_cnt++;
      end
      check("wd_lat", wd_cnt, WDOG + 1);
      check("wd_fault", 32'(Fault), 1);
      check("wd_cyc", 32'(CycCnt), WDOG);
      check("wd_run", 32'(Run), 0);
      tick();
      check("wd_ack_clr", 32'(Ack), 0);
      check("wd_idx", 32'(ProgIdx), 1);
      check("wd_fault_sticky", 32'(Fault), 1);
`else
      repeat (WDOG + 100) begin
         tick();
         wd_cnt += 32'(Ack);
      end
      check("nowd_run", 32'(Run), 1);
      check("nowd_cyc", 32'(CycCnt), WDOG + 100);
      check("nowd_ack", wd_cnt, 0);
      check("nowd_fault", 32'(Fault), 0);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      repeat (DRAIN) tick();
      check("nowd_ack_end", 32'(Ack), 1);
      tick();
      check("nowd_idx", 32'(ProgIdx), 1);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter L, 10, PC/address width.
REQ-002 Parameter NPROG, 3, number of resident programs.
REQ-003 Parameter CW, 16, cycle-counter width.
REQ-004 Parameter DRAIN, 2, pipeline-flush cycles after Done.
REQ-005 Clk  input  1  clock; all state changes on posedge only.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Start  input  1  request to launch next program; sampled in IDLE only.
REQ-008 Done  input  1  decoder flag: halt instruction executing.
REQ-009 PcLoad  output  1  force program counter to PcLoadAddr this cycle.
REQ-010 PcLoadAddr  output  L  base address of selected program.
REQ-011 Run  output  1  datapath/PC advance enable.
REQ-012 Ack  output  1  one-cycle pulse: current program finished.
REQ-013 ProgIdx  output  $clog2(NPROG)  index of current/next program.
REQ-014 CycCnt  output  CW  RUN-cycle count of current or last program.
REQ-015 AllDone  output  1  sticky: all NPROG programs finished.
REQ-016 Fault  output  1  sticky: watchdog abort occurred (see Configuration).

Function
REQ-017 FSM states IDLE, LOAD, RUN, FLUSH, FIN SHALL be used.
REQ-018 IDLE: Start=1 and AllDone=0 -> LOAD; else stay.
REQ-019 LOAD (1 cycle): PcLoad=1, PcLoadAddr=PROG_BASE[ProgIdx], CycCnt cleared to 0 -> RUN.
REQ-020 RUN: Run=1, CycCnt increments each cycle, saturating at 2^CW-1; Done=1 -> FLUSH.
REQ-021 FLUSH: Run=1 for exactly DRAIN cycles, CycCnt frozen -> FIN; DRAIN=0 goes straight to FIN.
REQ-022 FIN (1 cycle): Ack=1; if ProgIdx==NPROG-1 set AllDone and hold ProgIdx, else ProgIdx+1 -> IDLE.
REQ-023 Start outside IDLE, or while AllDone=1, SHALL be ignored with no side effects.
REQ-024 Done outside RUN SHALL be ignored; Start and Done in the same RUN cycle: Done acts, Start ignored.
REQ-025 PcLoad, Ack SHALL be high only in LOAD, FIN respectively; Run only in RUN/FLUSH.
REQ-026 Start-to-PcLoad latency SHALL be 1 cycle; Done-to-Ack latency DRAIN+1 cycles.

Reset
REQ-027 Reset low SHALL asynchronously force IDLE, ProgIdx=0, CycCnt=0, AllDone=0, Fault=0, all pulse outputs 0, PcLoadAddr=0.
REQ-028 Reset mid-RUN/FLUSH SHALL abort without an Ack pulse; operation resumes only after Reset high and a new Start.

Configuration
REQ-029 Macro PROG_SEQ_WDOG_EN defined: when CycCnt reaches WDOG_LIM in RUN, FSM SHALL go to FIN (skip FLUSH), set Fault, pulse Ack, advance ProgIdx per REQ-022.
REQ-030 Macro undefined: no watchdog logic; Fault tied to 0; RUN exits only on Done.

Structure
REQ-031 Package prog_seq_pkg SHALL hold the state enum, PROG_BASE table (defaults 0, 256, 512), and WDOG_LIM (default 1000).
REQ-032 Sub-module prog_cyc_ctr SHALL implement the saturating clear/enable/freeze counter for CycCnt.

Verification
REQ-033 Reset low, Start=1 -> no PcLoad; after release, Start pulse -> next cycle PcLoad=1, PcLoadAddr=0, ProgIdx=0.
REQ-034 Program 0 Done after 5 RUN cycles, DRAIN=2 -> CycCnt=5, Ack exactly 3 cycles after Done, ProgIdx=1.
REQ-035 Three Start/Done sequences -> PcLoadAddr 0, 256, 512; AllDone=1 after third Ack; fourth Start ignored.
REQ-036 Start pulsed during RUN and FLUSH, Done pulsed in IDLE -> state, ProgIdx, CycCnt unchanged.
REQ-037 Reset dropped in FLUSH -> immediate IDLE, no Ack, ProgIdx=0.
REQ-038 With PROG_SEQ_WDOG_EN, no Done for 1000 RUN cycles -> Fault=1, Ack pulse, ProgIdx advanced; without macro, Run remains high.
